// File: rtl/stopwatch_timer_avalon.sv
// Avalon-MM stopwatch: prescaled tick counter with lap capture, sticky overflow and level irq.
module stopwatch_timer_avalon #(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               out_port,
  output logic [COUNT_W-1:0] count_out,
  output logic               tick,
  output logic               irq
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(CLK_DIV - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_COUNT  = 2'd1;
  localparam logic [1:0] ADDR_LAP    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic               run;
  logic               irq_en;
  logic [PRE_W-1:0]   pre;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] lap;
  logic               ovf;
  logic               lap_valid;

  logic wr;
  logic wr_ctrl;
  logic wr_count;
  logic wr_status;
  logic clear_cmd;
  logic lap_cmd;
  logic tick_c;
  logic wrap_c;
  logic unused_wd;

  // Bus strobe decode; clear and lap are one-shot commands carried by a CTRL write.
  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == ADDR_CTRL);
  assign wr_count  = wr && (address == ADDR_COUNT);
  assign wr_status = wr && (address == ADDR_STATUS);
  assign clear_cmd = wr_ctrl & writedata[1];
  assign lap_cmd   = wr_ctrl & writedata[2];
  assign unused_wd = ^writedata;

  // Tick comes straight from registered state, so it is high the cycle before the count edge.
  assign tick_c = run && (pre == PRE_MAX);
  // A wrap only counts if the increment actually lands (clear and COUNT write override it).
  assign wrap_c = tick_c && (count == COUNT_MAX) && !clear_cmd && !wr_count;

  assign tick      = tick_c;
  assign out_port  = run;
  assign count_out = count;
  assign irq       = irq_en & ovf;

  // Control bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run    <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      run    <= writedata[0];
      irq_en <= writedata[3];
    end
  end

  // Prescaler: advances only while running, holds its fraction when paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (clear_cmd) begin
      pre <= '0;
    end else if (run) begin
      if (pre == PRE_MAX) pre <= '0;
      else                pre <= pre + PRE_W'(1);
    end
  end

  // Count register: clear beats a bus load, which beats the tick increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear_cmd) begin
      count <= '0;
    end else if (wr_count) begin
      count <= writedata[COUNT_W-1:0];
    end else if (tick_c) begin
      count <= count + COUNT_W'(1);
    end
  end

  // Lap capture takes the pre-update count value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap <= '0;
    end else if (lap_cmd) begin
      lap <= count;
    end
  end

  // Sticky status flags; a same-edge set wins over the W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf       <= 1'b0;
      lap_valid <= 1'b0;
    end else begin
      if (wrap_c)                         ovf <= 1'b1;
      else if (wr_status && writedata[0]) ovf <= 1'b0;

      if (lap_cmd)                        lap_valid <= 1'b1;
      else if (clear_cmd)                 lap_valid <= 1'b0;
      else if (wr_status && writedata[1]) lap_valid <= 1'b0;
    end
  end

  // Zero-latency register read mux; undefined bits read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata = {28'd0, irq_en, 2'b00, run};
      ADDR_COUNT:  readdata = 32'(count);
      ADDR_LAP:    readdata = 32'(lap);
      ADDR_STATUS: readdata = {30'd0, lap_valid, ovf};
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_stopwatch_timer_avalon.sv
// Directed self-checking bench for stopwatch_timer_avalon (CLK_DIV=4, COUNT_W=8).
module tb_stopwatch_timer_avalon;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_port;
  logic [7:0]  count_out;
  logic        tick;
  logic        irq;

  int tests;
  int fails;
  int cyc;
  int tick_cnt;
  int last_tick;
  int first_tick;
  int bad_gap;
  int n;
  logic [31:0] rd;

  stopwatch_timer_avalon #(.CLK_DIV(4), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .count_out(count_out), .tick(tick), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle to the next falling edge and log the tick seen there.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (tick) begin
      tick_cnt++;
      if (first_tick < 0) first_tick = cyc;
      if (last_tick >= 0 && (cyc - last_tick) != 4) bad_gap++;
      last_tick = cyc;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  // Step until tick is high (bounded); returns the number of steps taken.
  task automatic wait_tick(input string tag, output int steps);
    steps = 0;
    while (!tick && steps < 20) begin
      step();
      steps++;
    end
    check(tag, 32'(tick), 32'd1);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; tick_cnt = 0;
    last_tick = -1; first_tick = -1; bad_gap = 0;
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Reset asserted in the middle of a run.
    bus_write(2'd0, 32'h1);
    repeat (6) step();
    address = 2'd0; chipselect = 1'b1; write_n = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_out_port", 32'(out_port), 32'd0);
    check("rst_count_out", 32'(count_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    chipselect = 1'b0;
    step(); step();
    reset = 1'b0;

    // Basic count: 40 cycles after run -> 10 ticks, count 10.
    cyc = 0; tick_cnt = 0; last_tick = -1; first_tick = -1; bad_gap = 0;
    bus_write(2'd0, 32'h1);
    check("run_first_cycle_tick", 32'(tick), 32'd0);
    repeat (40) step();
    bus_read(2'd1, rd);
    check("count_after_40", rd, 32'd10);
    check("tick_pulses_40", 32'(tick_cnt), 32'd10);
    check("first_tick_pos", 32'(first_tick), 32'd4);
    check("tick_spacing", 32'(bad_gap), 32'd0);

    // Pause and resume keeps the prescaler fraction.
    bus_write(2'd0, 32'h3);
    repeat (5) step();
    bus_write(2'd0, 32'h0);
    tick_cnt = 0;
    repeat (20) step();
    check("pause_count_hold", 32'(count_out), 32'd1);
    check("pause_no_tick", 32'(tick_cnt), 32'd0);
    bus_write(2'd0, 32'h1);
    check("resume_no_tick_yet", 32'(tick), 32'd0);
    step();
    check("resume_tick_early", 32'(tick), 32'd1);
    step();
    check("resume_count", 32'(count_out), 32'd2);

    // Overflow raises ovf and irq; W1C drops irq.
    bus_write(2'd0, 32'h2);
    bus_write(2'd1, 32'hFF);
    bus_write(2'd0, 32'h9);
    wait_tick("ovf_wait_tick", n);
    check("ovf_tick_count_ff", 32'(count_out), 32'hFF);
    step();
    check("ovf_count_wrap", 32'(count_out), 32'h00);
    bus_read(2'd3, rd);
    check("ovf_status", rd, 32'h1);
    check("ovf_irq", 32'(irq), 32'd1);
    bus_write(2'd3, 32'h1);
    check("ovf_irq_cleared", 32'(irq), 32'd0);
    bus_read(2'd3, rd);
    check("ovf_status_cleared", rd, 32'h0);

    // Lap captured on a tick edge gets the old count.
    bus_write(2'd0, 32'h2);
    bus_write(2'd1, 32'h5);
    bus_write(2'd0, 32'h1);
    wait_tick("lap_wait_tick", n);
    check("lap_count_before", 32'(count_out), 32'h5);
    bus_write(2'd0, 32'h5);
    bus_read(2'd2, rd);
    check("lap_value", rd, 32'h5);
    bus_read(2'd1, rd);
    check("lap_count_after", rd, 32'h6);
    bus_read(2'd3, rd);
    check("lap_valid", rd, 32'h2);
    bus_read(2'd0, rd);
    check("lap_ctrl_selfclear", rd, 32'h1);

    // Clear on a tick edge: count/pre restart, run stays, lap_valid drops.
    wait_tick("clr_wait_tick", n);
    bus_write(2'd0, 32'h3);
    check("clr_count", 32'(count_out), 32'd0);
    check("clr_run", 32'(out_port), 32'd1);
    bus_read(2'd3, rd);
    check("clr_status", rd, 32'h0);
    bus_read(2'd2, rd);
    check("clr_lap_kept", rd, 32'h5);
    wait_tick("clr_next_tick", n);
    check("clr_tick_delay", 32'(n), 32'd3);

    // W1C on the same edge as a wrap: set wins.
    bus_write(2'd0, 32'h2);
    bus_write(2'd1, 32'hFF);
    bus_write(2'd0, 32'h1);
    wait_tick("race_wait_tick", n);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd);
    check("race_ovf_kept", rd, 32'h1);
    check("race_count_wrap", 32'(count_out), 32'h0);
    check("race_irq_disabled", 32'(irq), 32'd0);

    // COUNT write on a tick edge beats the increment.
    wait_tick("ldw_wait_tick", n);
    bus_write(2'd1, 32'h20);
    bus_read(2'd1, rd);
    check("load_vs_tick", rd, 32'h20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
